// File: rtl/gray_pkg.sv
// gray_pkg: shared FSM encodings, mode/dir constants and Gray helpers for the sweep controller
package gray_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction
endpackage

// File: rtl/gray_step_unit.sv
// gray_step_unit: next binary code (inc/dec with reload at terminal) and terminal detect
module gray_step_unit import gray_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  input  logic             dir,
  output logic [WIDTH-1:0] next_bin,
  output logic             terminal
);
  logic [WIDTH-1:0] start_val;
  always_comb begin
    start_val = (dir == DIR_DOWN) ? '1 : '0;
    terminal  = (bin == ((dir == DIR_DOWN) ? '0 : '1));
    next_bin  = terminal ? start_val : ((dir == DIR_DOWN) ? bin - WIDTH'(1) : bin + WIDTH'(1));
  end
endmodule

// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: binary/Gray code sweep source on a valid/ready stream; GRAY_SWEEP_CHECK_EN adds check_err
module gray_sweep_ctrl import gray_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
`ifdef GRAY_SWEEP_CHECK_EN
  output logic             check_err,
`endif
  output logic             done
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d, next_bin;
  logic             mode_q, mode_d, dir_q, dir_d, terminal, xfer, start_acc;
  gray_step_unit #(.WIDTH(WIDTH)) u_step (
    .bin      (bin_q),
    .dir      (dir_q),
    .next_bin (next_bin),
    .terminal (terminal)
  );
  assign out_valid = (state_q == ST_RUN);
  assign busy      = out_valid;
  assign done      = (state_q == ST_DONE);
  assign bin       = bin_q;
  assign gray      = WIDTH'(bin2gray(32'(bin_q)));
  assign xfer      = out_valid & out_ready;
  assign start_acc = (state_q == ST_IDLE) & start;
  // stop beats stepping: a same-cycle transfer is delivered but bin keeps its value
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    if (start_acc) begin
      state_d = ST_RUN;
      mode_d  = mode;
      dir_d   = dir;
      bin_d   = (dir == DIR_DOWN) ? '1 : '0;
    end else if (state_q == ST_RUN) begin
      if (stop) state_d = ST_IDLE;
      else if (xfer && terminal && mode_q == MODE_ONESHOT) state_d = ST_DONE;
      else if (xfer) bin_d = next_bin;
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end
`ifdef GRAY_SWEEP_CHECK_EN
  logic [WIDTH-1:0] last_gray_q, last_gray_d;
  logic             have_last_q, have_last_d, check_err_q, check_err_d;
  always_comb begin
    last_gray_d = xfer ? gray : last_gray_q;
    have_last_d = start_acc ? 1'b0 : (have_last_q | xfer);
    check_err_d = start_acc ? 1'b0 :
                  (check_err_q | (xfer & have_last_q & !is_onehot(32'(gray ^ last_gray_q))));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gray_q <= '0;
      have_last_q <= 1'b0;
      check_err_q <= 1'b0;
    end else begin
      last_gray_q <= last_gray_d;
      have_last_q <= have_last_d;
      check_err_q <= check_err_d;
    end
  end
  assign check_err = check_err_q;
`endif
endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// tb_gray_sweep_ctrl: directed vector table plus sweep sequences for gray_sweep_ctrl (WIDTH=4)
module tb_gray_sweep_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 0, stop = 0, mode = 0, dir = 0, out_ready = 0;
  logic       out_valid, busy, done;
  logic [3:0] bin, gray;
`ifdef GRAY_SWEEP_CHECK_EN
  logic       check_err;
`endif
  int n_tests = 0, n_fail = 0;
  gray_sweep_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .out_valid(out_valid), .out_ready(out_ready), .bin(bin), .gray(gray), .busy(busy),
`ifdef GRAY_SWEEP_CHECK_EN
    .check_err(check_err),
`endif
    .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st, sp, md, dr, rdy;
    logic v; logic [3:0] b; logic [3:0] g; logic bz; logic dn;
  } vec_t;
  vec_t vt[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] g_of(input logic [3:0] b);
    logic [3:0] g;
    for (int i = 0; i < 3; i++) g[i] = b[i] ^ b[i+1];
    g[3] = b[3];
    return g;
  endfunction
  task automatic sweep(input logic m, input logic d, input int n_xfer, input bit rnd);
    logic [3:0] e;
    int cnt, cyc;
    start = 1; mode = m; dir = d; stop = 0; out_ready = 0;
    step();
    start = 0; mode = ~m; dir = ~d;
    e = d ? 4'hF : 4'h0;
    cnt = 0; cyc = 0;
    while (cnt < n_xfer && cyc < 1000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("sweep_valid", 32'(out_valid), 32'd1);
      chk("sweep_bin", 32'(bin), 32'(e));
      chk("sweep_gray", 32'(gray), 32'(g_of(e)));
      chk("sweep_done", 32'(done), 32'd0);
      step();
      cyc++;
      if (out_ready) begin
        cnt++;
        e = d ? e - 4'd1 : e + 4'd1;
      end
    end
    if (cyc >= 1000) chk("sweep_timeout", 32'(cnt), 32'(n_xfer));
  endtask
  task automatic check_done_pulse();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
    out_ready = 0;
    step();
    chk("done_gone", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask
  initial begin
    //          st sp md dr rdy  v  b      g      bz dn
    vt[0]  = '{0, 0, 0, 0, 0,   0, 4'h0, 4'h0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 0,   0, 4'h0, 4'h0, 0, 0};
    vt[2]  = '{1, 1, 0, 0, 0,   1, 4'h0, 4'h0, 1, 0};
    vt[3]  = '{1, 0, 1, 1, 0,   1, 4'h0, 4'h0, 1, 0};
    vt[4]  = '{0, 0, 0, 0, 1,   1, 4'h1, 4'h1, 1, 0};
    vt[5]  = '{0, 0, 0, 0, 1,   1, 4'h2, 4'h3, 1, 0};
    vt[6]  = '{0, 0, 0, 0, 0,   1, 4'h2, 4'h3, 1, 0};
    vt[7]  = '{0, 0, 0, 1, 1,   1, 4'h3, 4'h2, 1, 0};
    vt[8]  = '{0, 1, 0, 0, 1,   0, 4'h3, 4'h2, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 1,   0, 4'h3, 4'h2, 0, 0};
    vt[10] = '{1, 0, 0, 1, 0,   1, 4'hF, 4'h8, 1, 0};
    vt[11] = '{0, 0, 0, 0, 1,   1, 4'hE, 4'h9, 1, 0};
    vt[12] = '{0, 1, 0, 0, 0,   0, 4'hE, 4'h9, 0, 0};
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_gray", 32'(gray), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #10 rst_n = 1;
    step();
    for (int i = 0; i < 13; i++) begin
      start = vt[i].st; stop = vt[i].sp; mode = vt[i].md; dir = vt[i].dr; out_ready = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].v));
      chk($sformatf("vec%0d_bin", i), 32'(bin), 32'(vt[i].b));
      chk($sformatf("vec%0d_gray", i), 32'(gray), 32'(vt[i].g));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].bz));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].dn));
    end
    start = 0; stop = 0; out_ready = 0;
    step();
    sweep(0, 0, 16, 0);
    check_done_pulse();
    sweep(0, 1, 16, 0);
    check_done_pulse();
    sweep(0, 0, 16, 1);
    check_done_pulse();
    sweep(1, 0, 40, 0);
    chk("cont_bin_after40", 32'(bin), 32'h8);
    out_ready = 1; stop = 1;
    step();
    stop = 0; out_ready = 0;
    chk("cont_stop_valid", 32'(out_valid), 32'd0);
    chk("cont_stop_busy", 32'(busy), 32'd0);
    chk("cont_stop_done", 32'(done), 32'd0);
    sweep(0, 0, 5, 0);
    out_ready = 0; stop = 1;
    step();
    stop = 0;
    chk("stop5_valid", 32'(out_valid), 32'd0);
    chk("stop5_bin", 32'(bin), 32'h5);
    chk("stop5_done", 32'(done), 32'd0);
    step();
    chk("stop5_done_later", 32'(done), 32'd0);
    sweep(0, 0, 10, 0);
    chk("pre_rst_bin", 32'(bin), 32'hA);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_bin", 32'(bin), 32'd0);
    chk("arst_gray", 32'(gray), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
`ifdef GRAY_SWEEP_CHECK_EN
    chk("arst_check_err", 32'(check_err), 32'd0);
`endif
    out_ready = 0;
    #3 rst_n = 1;
    step();
    sweep(0, 0, 16, 0);
    check_done_pulse();
`ifdef GRAY_SWEEP_CHECK_EN
    chk("check_err_final", 32'(check_err), 32'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
